// File: rtl/bcd_pkg.sv
// Shared BCD types, digit limits and the digit validity helper used by the counter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MIN = 4'd0;
  localparam bcd_digit_t BCD_MAX = 4'd9;

  function automatic logic bcd_valid(input bcd_digit_t digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of the cascade: increments/decrements on carry-in and reports carry/borrow out.
module bcd_digit_step
  import bcd_pkg::*;
(
  input  bcd_digit_t i_digit,
  input  logic       i_up,
  input  logic       i_cin,
  output bcd_digit_t o_next,
  output logic       o_cout
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    o_next = i_digit;
    o_cout = 1'b0;
    if (i_cin) begin
      if (i_up) begin
        if (i_digit == BCD_MAX) begin
          o_next = BCD_MIN;
          o_cout = 1'b1;
        end else begin
          o_next = i_digit + 4'd1;
        end
      end else begin
        if (i_digit == BCD_MIN) begin
          o_next = BCD_MAX;
          o_cout = 1'b1;
        end else begin
          o_next = i_digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with load validation, wrap/saturate limits and terminal count.
// Optional build macro BCD_CNT_AUTORELOAD_EN: down-wrap at zero reloads the last accepted load value.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter bit SAT    = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic              en,
  input  logic              up,
  output logic [4*DIGITS-1:0] q,
  output logic              tc,
  output logic              zero,
  output logic              err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]    r_q;
  logic            r_err;
  logic [DIGITS:0] w_carry;
  logic [W-1:0]    w_step;
  logic [W-1:0]    w_next;
  logic            w_limit;
  logic            w_load_ok;

`ifdef BCD_CNT_AUTORELOAD_EN
  logic [W-1:0] r_reload;
`endif

  // Digit 0 always steps; the chain's final carry/borrow out means the whole count sits at its limit.
  assign w_carry[0] = 1'b1;
  assign w_limit    = w_carry[DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_step u_step (
      .i_digit (r_q[4*g +: 4]),
      .i_up    (up),
      .i_cin   (w_carry[g]),
      .o_next  (w_step[4*g +: 4]),
      .o_cout  (w_carry[g+1])
    );
  end

  always_comb begin
    w_load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      w_load_ok = w_load_ok & bcd_valid(load_val[4*i +: 4]);
    end
  end

  // The chain already wraps MAX->0 and 0->MAX; only saturation and reload override it.
  always_comb begin
    w_next = w_step;
    if (w_limit) begin
      if (SAT) begin
        w_next = r_q;
      end else if (!up) begin
`ifdef BCD_CNT_AUTORELOAD_EN
        w_next = r_reload;
`else
        w_next = w_step;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
      r_q   <= '0;
      r_err <= 1'b0;
`ifdef BCD_CNT_AUTORELOAD_EN
      r_reload <= '0;
`endif
    end else begin
      r_err <= 1'b0;
      if (clr) begin
        r_q <= '0;
      end else if (load) begin
        if (w_load_ok) begin
          r_q <= load_val;
`ifdef BCD_CNT_AUTORELOAD_EN
          r_reload <= load_val;
`endif
        end else begin
          r_err <= 1'b1;
        end
      end else if (en) begin
        r_q <= w_next;
      end
    end
  end

  assign q    = r_q;
  assign err  = r_err;
  assign zero = (r_q == '0);
  assign tc   = en & ~clr & ~load & w_limit;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter: wrap, saturate and cascaded-digit instances.
module tb_bcd_updown_counter;

`ifdef BCD_CNT_AUTORELOAD_EN
  localparam logic [7:0] RELOAD_EXP = 8'h10;
`else
  localparam logic [7:0] RELOAD_EXP = 8'h99;
`endif

  logic       clk = 1'b0;
  logic       rstn, clr, load, en, up;
  logic [7:0] load_val;

  logic [7:0] q_w, q_s;
  logic       tc_w, z_w, e_w, tc_s, z_s, e_s;
  logic [3:0] q_lo, q_hi;
  logic       tc_lo, tc_hi, z_lo, z_hi, e_lo, e_hi;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(2), .SAT(1'b0)) u_wrap (
    .clk(clk), .rstn(rstn), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .q(q_w), .tc(tc_w), .zero(z_w), .err(e_w));

  bcd_updown_counter #(.DIGITS(2), .SAT(1'b1)) u_sat (
    .clk(clk), .rstn(rstn), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .q(q_s), .tc(tc_s), .zero(z_s), .err(e_s));

  bcd_updown_counter #(.DIGITS(1), .SAT(1'b0)) u_lo (
    .clk(clk), .rstn(rstn), .clr(clr), .load(load), .load_val(load_val[3:0]),
    .en(en), .up(up), .q(q_lo), .tc(tc_lo), .zero(z_lo), .err(e_lo));

  bcd_updown_counter #(.DIGITS(1), .SAT(1'b0)) u_hi (
    .clk(clk), .rstn(rstn), .clr(clr), .load(load), .load_val(load_val[7:4]),
    .en(tc_lo), .up(up), .q(q_hi), .tc(tc_hi), .zero(z_hi), .err(e_hi));

  // sel: 0 = wrap instance, 1 = saturating instance, 2 = wrap plus cascaded pair, 3 = no check
  typedef struct {
    int         sel;
    logic [7:0] q;
    logic       tc;
    logic       zero;
    logic       err;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 ns after the edge; the record describes outputs seen mid-cycle.
  task automatic cyc(input logic r, input logic c, input logic l, input logic [7:0] lv,
                     input logic e, input logic u, input int sel, input logic [7:0] eq,
                     input logic etc, input logic ez, input logic ee, input string name);
    exp_t x;
    @(posedge clk);
    #1;
    rstn = r; clr = c; load = l; load_val = lv; en = e; up = u;
    x.sel = sel; x.q = eq; x.tc = etc; x.zero = ez; x.err = ee; x.name = name;
    sb.push_back(x);
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_x = sb.pop_front();
      if (mon_x.sel == 0 || mon_x.sel == 2) begin
        check({mon_x.name, ".q"},    q_w,  mon_x.q);
        check({mon_x.name, ".tc"},   {7'd0, tc_w}, {7'd0, mon_x.tc});
        check({mon_x.name, ".zero"}, {7'd0, z_w},  {7'd0, mon_x.zero});
        check({mon_x.name, ".err"},  {7'd0, e_w},  {7'd0, mon_x.err});
`ifndef BCD_CNT_AUTORELOAD_EN
        if (mon_x.sel == 2) check({mon_x.name, ".chain_q"}, {q_hi, q_lo}, mon_x.q);
`endif
      end else if (mon_x.sel == 1) begin
        check({mon_x.name, ".q"},    q_s,  mon_x.q);
        check({mon_x.name, ".tc"},   {7'd0, tc_s}, {7'd0, mon_x.tc});
        check({mon_x.name, ".zero"}, {7'd0, z_s},  {7'd0, mon_x.zero});
        check({mon_x.name, ".err"},  {7'd0, e_s},  {7'd0, mon_x.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   v;
    logic re, ru;
    rstn = 1'b0; clr = 1'b0; load = 1'b0; load_val = 8'h00; en = 1'b0; up = 1'b0;

    // Reset, async reset, clear over load
    cyc(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, "reset");
    cyc(1, 0, 1, 8'h47, 0, 0, 0, 8'h00, 0, 1, 0, "pre_load47");
    cyc(1, 0, 0, 8'h00, 0, 0, 0, 8'h47, 0, 0, 0, "load47");
    cyc(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, "async_rst");
    cyc(1, 0, 1, 8'h12, 0, 0, 0, 8'h00, 0, 1, 0, "post_rst");
    cyc(1, 1, 1, 8'h47, 1, 1, 0, 8'h12, 0, 0, 0, "load12");
    cyc(1, 0, 1, 8'h98, 0, 0, 0, 8'h00, 0, 1, 0, "clr_over_load");

    // Up count, wrap and carry
    cyc(1, 0, 0, 8'h00, 1, 1, 0, 8'h98, 0, 0, 0, "load98");
    cyc(1, 0, 0, 8'h00, 1, 1, 0, 8'h99, 1, 0, 0, "up_max_tc");
    cyc(1, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 1, 0, "wrap_up");
    cyc(1, 0, 1, 8'h19, 0, 0, 0, 8'h01, 0, 0, 0, "up01");
    cyc(1, 0, 0, 8'h00, 1, 1, 0, 8'h19, 0, 0, 0, "load19");
    cyc(1, 0, 1, 8'h10, 0, 0, 0, 8'h20, 0, 0, 0, "carry");

    // Down count, borrow and down-wrap
    cyc(1, 0, 0, 8'h00, 1, 0, 0, 8'h10, 0, 0, 0, "load10");
    cyc(1, 0, 0, 8'h00, 1, 0, 0, 8'h09, 0, 0, 0, "borrow");
    for (int k = 8; k >= 1; k--)
      cyc(1, 0, 0, 8'h00, 1, 0, 0, 8'(k), 0, 0, 0, "down_step");
    cyc(1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 1, 0, "down_zero_tc");
    cyc(1, 0, 1, 8'h50, 0, 0, 0, RELOAD_EXP, 0, 0, 0, "down_wrap");

    // Direction toggled every cycle
    cyc(1, 0, 0, 8'h00, 1, 1, 0, 8'h50, 0, 0, 0, "toggle_a");
    cyc(1, 0, 0, 8'h00, 1, 0, 0, 8'h51, 0, 0, 0, "toggle_b");
    cyc(1, 0, 0, 8'h00, 1, 1, 0, 8'h50, 0, 0, 0, "toggle_c");
    cyc(1, 0, 0, 8'h00, 1, 0, 0, 8'h51, 0, 0, 0, "toggle_d");
    cyc(1, 0, 1, 8'h35, 0, 0, 0, 8'h50, 0, 0, 0, "toggle_e");

    // Rejected load with a concurrent count request
    cyc(1, 0, 1, 8'h3A, 1, 1, 0, 8'h35, 0, 0, 0, "load35");
    cyc(1, 0, 0, 8'h00, 0, 0, 0, 8'h35, 0, 0, 1, "err_pulse");
    cyc(1, 0, 1, 8'h29, 0, 0, 0, 8'h35, 0, 0, 0, "err_clear");
    cyc(1, 0, 0, 8'h00, 0, 0, 0, 8'h29, 0, 0, 0, "load29");

    // Saturating instance
    cyc(1, 1, 0, 8'h00, 0, 0, 3, 8'h00, 0, 0, 0, "sat_clr");
    cyc(1, 0, 1, 8'h99, 0, 0, 1, 8'h00, 0, 1, 0, "sat_load");
    cyc(1, 0, 0, 8'h00, 1, 1, 1, 8'h99, 1, 0, 0, "sat_up_max");
    cyc(1, 0, 0, 8'h00, 1, 1, 1, 8'h99, 1, 0, 0, "sat_hold_1");
    cyc(1, 1, 0, 8'h00, 0, 0, 1, 8'h99, 0, 0, 0, "sat_hold_2");
    cyc(1, 0, 0, 8'h00, 1, 0, 1, 8'h00, 1, 1, 0, "sat_zero_tc");
    cyc(1, 0, 0, 8'h00, 1, 0, 1, 8'h00, 1, 1, 0, "sat_hold_zero");
    cyc(1, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 1, 0, "sat_zero_stay");

    // Cascaded single digits against a decimal model, random en/up
    cyc(1, 0, 1, 8'h50, 0, 0, 3, 8'h00, 0, 0, 0, "casc_load");
    v = 50;
    for (int i = 0; i < 250; i++) begin
      re = 1'($urandom_range(0, 1));
      ru = 1'($urandom_range(0, 1));
      cyc(1, 0, 0, 8'h00, re, ru, 2, to_bcd(v),
          re && ((ru && v == 99) || (!ru && v == 0)), v == 0, 0, "cascade");
      if (re) begin
        if (ru) v = (v + 1) % 100;
`ifdef BCD_CNT_AUTORELOAD_EN
        else if (v == 0) v = 50;
`endif
        else v = (v + 99) % 100;
      end
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d records left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
